// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Responder end of the datapath memory request interface.
//                Arbitrates instruction fetches and data loads/stores onto a
//                single-ported RAM, with absolute data priority, one-cycle
//                completion pulses and a timeout trap for a hung RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DREQ = 3'd1,
        IREQ = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [1:0] c_RAM_ACCESS   = 2'd2;
    localparam logic [1:0] c_RAM_ERROR    = 2'd3;
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_CNT_MAX      = 8'hFF;

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_ihit, w_ihit;
    logic        r_dhit, w_dhit;
    logic [31:0] r_iload, w_iload;
    logic [31:0] r_dload, w_dload;
    logic        r_ramREN, w_ramREN;
    logic        r_ramWEN, w_ramWEN;
    logic [31:0] r_ramaddr, w_ramaddr;
    logic [31:0] r_ramstore, w_ramstore;
    logic        r_memerr, w_memerr;
    logic        w_req_held;

    // Next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_ihit     = 1'b0;
        w_dhit     = 1'b0;
        w_iload    = r_iload;
        w_dload    = r_dload;
        w_ramREN   = r_ramREN;
        w_ramWEN   = r_ramWEN;
        w_ramaddr  = r_ramaddr;
        w_ramstore = r_ramstore;
        w_memerr   = r_memerr;
        w_req_held = (r_state == DREQ) ? (dREN | dWEN) : iREN;

        case (r_state)
            IDLE: begin
                if (dREN || dWEN) begin
                    // Store wins when both load and store are requested
                    w_state    = DREQ;
                    w_cnt      = 8'd0;
                    w_ramaddr  = daddr;
                    w_ramstore = dstore;
                    w_ramWEN   = dWEN;
                    w_ramREN   = dREN & ~dWEN;
                end else if (iREN) begin
                    w_state   = IREQ;
                    w_cnt     = 8'd0;
                    w_ramaddr = iaddr;
                    w_ramREN  = 1'b1;
                    w_ramWEN  = 1'b0;
                end
            end

            DREQ, IREQ: begin
                if (ramstate == c_RAM_ACCESS) begin
                    // Completion beats a same-cycle request drop
                    w_state  = DONE;
                    w_ramREN = 1'b0;
                    w_ramWEN = 1'b0;
                    if (r_state == DREQ) begin
                        w_dhit = 1'b1;
                        if (r_ramREN) begin
                            w_dload = ramload;
                        end
                    end else begin
                        w_ihit  = 1'b1;
                        w_iload = ramload;
                    end
                end else if ((ramstate == c_RAM_ERROR) || (r_cnt >= c_TIMEOUT_LAST)) begin
                    w_state  = ERR;
                    w_ramREN = 1'b0;
                    w_ramWEN = 1'b0;
                    w_memerr = 1'b1;
                end else if (!w_req_held) begin
                    w_state  = IDLE;
                    w_ramREN = 1'b0;
                    w_ramWEN = 1'b0;
                end else begin
                    w_cnt = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 8'd1;
                end
            end

            DONE: begin
                // Requester still shows its stale request here, so it is ignored
                w_state = IDLE;
                w_cnt   = 8'd0;
            end

            ERR: begin
                w_ramREN = 1'b0;
                w_ramWEN = 1'b0;
                w_memerr = 1'b1;
            end

            default: begin
                w_state  = IDLE;
                w_ramREN = 1'b0;
                w_ramWEN = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_iload    <= 32'h0;
            r_dload    <= 32'h0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= 32'h0;
            r_ramstore <= 32'h0;
            r_memerr   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_ihit     <= w_ihit;
            r_dhit     <= w_dhit;
            r_iload    <= w_iload;
            r_dload    <= w_dload;
            r_ramREN   <= w_ramREN;
            r_ramWEN   <= w_ramWEN;
            r_ramaddr  <= w_ramaddr;
            r_ramstore <= w_ramstore;
            r_memerr   <= w_memerr;
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign memerr   = r_memerr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter with a behavioural RAM,
//                directed boundary cases and randomized concurrent requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic        st;
        logic [31:0] val;
    } dexp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_dload;
    logic [31:0] iq [$];
    dexp_t       dq [$];

    // RAM model state
    logic [31:0] ram [logic [31:0]];
    int          fixed_lat = 0;
    bit          force_busy = 0;
    bit          force_err  = 0;
    int          acc_starts = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    // Power-on RAM image, shared by the RAM model and the reference model
    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h2002_0001;
            32'h100: return 32'hDEAD_BEEF;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_hit(input bit is_d, input int limit, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge CLK);
            n++;
            if (is_d ? dhit : ihit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Behavioural RAM: BUSY for a chosen number of cycles, then one ACCESS cycle
    initial begin
        int bcnt;
        int cur_lat;
        bcnt     = 0;
        cur_lat  = 0;
        ramstate = 2'd0;
        ramload  = 32'h0;
        forever begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                if (force_err) begin
                    ramstate = 2'd3;
                end else if (force_busy || bcnt < cur_lat) begin
                    ramstate = 2'd1;
                    bcnt++;
                end else begin
                    ramstate = 2'd2;
                    if (ramWEN) ram[ramaddr] = ramstore;
                    else        ramload = ram_rd(ramaddr);
                end
            end else begin
                ramstate = 2'd0;
                bcnt     = 0;
                cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            end
        end
    end

    // Monitor: pops the scoreboard whenever a hit is presented
    initial begin
        bit    prev_en, prev_ih, prev_dh;
        dexp_t e;
        prev_en = 0; prev_ih = 0; prev_dh = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_en = 0; prev_ih = 0; prev_dh = 0;
            end else begin
                if ((ramREN || ramWEN) && !prev_en) acc_starts++;
                if (ihit || dhit) chk("hit_exclusive", 32'(ihit && dhit), 32'd0);
                if (ihit) begin
                    chk("ihit_single_cycle", 32'(prev_ih), 32'd0);
                    chk("ihit_pending", 32'(iq.size() != 0), 32'd1);
                    if (iq.size() != 0) chk("iload", iload, iq.pop_front());
                end
                if (dhit) begin
                    chk("dhit_single_cycle", 32'(prev_dh), 32'd0);
                    chk("dhit_pending", 32'(dq.size() != 0), 32'd1);
                    if (dq.size() != 0) begin
                        e = dq.pop_front();
                        chk("dload", dload, e.val);
                    end
                end
                prev_en = ramREN || ramWEN;
                prev_ih = ihit;
                prev_dh = dhit;
            end
        end
    end

    task automatic run_d(input int n);
        bit          ok;
        logic [31:0] a, v;
        int          kind;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            a    = 32'h1000 + 32'($urandom_range(0, 7) << 2);
            kind = int'($urandom_range(0, 3));
            if (kind >= 2) begin
                v = $urandom;
                ref_mem[a] = v;
                dq.push_back({1'b1, last_dload});
                dREN = (kind == 3); dWEN = 1'b1; dstore = v;
            end else begin
                v = ref_rd(a);
                last_dload = v;
                dq.push_back({1'b0, v});
                dREN = 1'b1; dWEN = 1'b0; dstore = $urandom;
            end
            daddr = a;
            wait_hit(1'b1, 300, ok);
            chk("rand_d_wait", 32'(ok), 32'd1);
            @(negedge CLK);
            dREN = 1'b0; dWEN = 1'b0;
        end
    endtask

    task automatic run_i(input int n);
        bit          ok;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            a = 32'($urandom_range(0, 63) << 2);
            iq.push_back(ref_rd(a));
            iaddr = a;
            iREN  = 1'b1;
            wait_hit(1'b0, 300, ok);
            chk("rand_i_wait", 32'(ok), 32'd1);
            @(negedge CLK);
            iREN = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        last_dload = 32'h0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ihit", 32'(ihit), 0);
        chk("rst_dhit", 32'(dhit), 0);
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_ramWEN", 32'(ramWEN), 0);
        chk("rst_memerr", 32'(memerr), 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);

        // Single fetch with a 1-cycle RAM
        RST = 1'b0;
        iaddr = 32'h40; iREN = 1'b1; iq.push_back(ref_rd(32'h40));
        @(negedge CLK);
        chk("t1_ramREN_c1", 32'(ramREN), 1);
        chk("t1_ramaddr_c1", ramaddr, 32'h40);
        chk("t1_ihit_c1", 32'(ihit), 0);
        @(negedge CLK);
        chk("t1_ihit_c2", 32'(ihit), 1);
        @(negedge CLK);
        chk("t1_ihit_c3", 32'(ihit), 0);
        chk("t1_ramREN_c3", 32'(ramREN), 0);
        iREN = 1'b0;
        repeat (2) @(negedge CLK);

        // Simultaneous data load and fetch: data first
        daddr = 32'h100; dREN = 1'b1; iaddr = 32'h44; iREN = 1'b1;
        last_dload = ref_rd(32'h100);
        dq.push_back({1'b0, last_dload});
        iq.push_back(ref_rd(32'h44));
        @(negedge CLK);
        chk("t2_ramaddr_d", ramaddr, 32'h100);
        chk("t2_ramREN_d", 32'(ramREN), 1);
        @(negedge CLK);
        chk("t2_dhit", 32'(dhit), 1);
        chk("t2_ihit_c2", 32'(ihit), 0);
        @(negedge CLK);
        dREN = 1'b0;
        chk("t2_idle_ramREN", 32'(ramREN), 0);
        @(negedge CLK);
        chk("t2_ramaddr_i", ramaddr, 32'h44);
        chk("t2_ramREN_i", 32'(ramREN), 1);
        @(negedge CLK);
        chk("t2_ihit", 32'(ihit), 1);
        @(negedge CLK);
        iREN = 1'b0;
        fixed_lat = 3;
        repeat (2) @(negedge CLK);

        // Store with 3 BUSY cycles
        daddr = 32'h200; dstore = 32'h1234_5678; dWEN = 1'b1;
        ref_mem[32'h200] = 32'h1234_5678;
        dq.push_back({1'b1, last_dload});
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            chk("t3_ramWEN", 32'(ramWEN), 1);
            chk("t3_ramREN", 32'(ramREN), 0);
            chk("t3_ramstore", ramstore, 32'h1234_5678);
            chk("t3_dhit_early", 32'(dhit), 0);
        end
        @(negedge CLK);
        chk("t3_dhit", 32'(dhit), 1);
        chk("t3_ramWEN_done", 32'(ramWEN), 0);
        @(negedge CLK);
        dWEN = 1'b0;
        fixed_lat = 0;
        repeat (2) @(negedge CLK);

        // Request held through the hit cycle causes exactly one access
        s = acc_starts;
        daddr = 32'h200; dREN = 1'b1;
        last_dload = ref_rd(32'h200);
        dq.push_back({1'b0, last_dload});
        wait_hit(1'b1, 20, ok);
        chk("t4_dhit_seen", 32'(ok), 1);
        @(negedge CLK);
        dREN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t4_one_access", 32'(acc_starts - s), 1);

        // Randomized concurrent requesters against random RAM latency
        fixed_lat = -1;
        fork
            run_d(40);
            run_i(40);
        join
        fixed_lat = 0;
        force_busy = 1'b1;
        repeat (3) @(negedge CLK);

        // Timeout trap with RAM stuck BUSY
        daddr = 32'h300; dREN = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge CLK);
            chk("t6_memerr_pre", 32'(memerr), 0);
            chk("t6_ramREN_pre", 32'(ramREN), 1);
        end
        @(negedge CLK);
        chk("t6_memerr", 32'(memerr), 1);
        chk("t6_ramREN_err", 32'(ramREN), 0);
        chk("t6_ramWEN_err", 32'(ramWEN), 0);
        dREN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6_memerr_sticky", 32'(memerr), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_memerr_rst", 32'(memerr), 0);
        chk("t6_ramREN_rst", 32'(ramREN), 0);
        RST = 1'b0; force_busy = 1'b0; force_err = 1'b1;
        last_dload = 32'h0;
        @(negedge CLK);

        // RAM reports ERROR
        daddr = 32'h304; dstore = 32'h5; dWEN = 1'b1;
        @(negedge CLK);
        chk("t6e_ramWEN", 32'(ramWEN), 1);
        @(negedge CLK);
        chk("t6e_memerr", 32'(memerr), 1);
        chk("t6e_ramWEN_err", 32'(ramWEN), 0);
        dWEN = 1'b0; RST = 1'b1;
        @(negedge CLK);
        chk("t6e_memerr_rst", 32'(memerr), 0);
        RST = 1'b0; force_err = 1'b0; force_busy = 1'b1;
        @(negedge CLK);

        // Reset in the middle of a fetch, then a fresh fetch
        iaddr = 32'h48; iREN = 1'b1;
        @(negedge CLK);
        chk("t7_ramREN_c1", 32'(ramREN), 1);
        @(negedge CLK);
        chk("t7_ramREN_c2", 32'(ramREN), 1);
        RST = 1'b1; iREN = 1'b0;
        @(negedge CLK);
        chk("t7_ramREN_rst", 32'(ramREN), 0);
        chk("t7_ihit_rst", 32'(ihit), 0);
        RST = 1'b0; force_busy = 1'b0;
        last_dload = 32'h0;
        repeat (2) @(negedge CLK);
        iaddr = 32'h48; iREN = 1'b1;
        iq.push_back(ref_rd(32'h48));
        wait_hit(1'b0, 20, ok);
        chk("t7_fresh_ihit", 32'(ok), 1);
        @(negedge CLK);
        iREN = 1'b0;
        repeat (4) @(negedge CLK);

        chk("iq_drained", 32'(iq.size()), 0);
        chk("dq_drained", 32'(dq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the datapath memory request interface: accepts instruction fetches (iREN) and data load/store requests (dREN/dWEN) and arbitrates them onto a single-ported RAM.
- Returns single-cycle ihit/dhit completion pulses with load data.
- Data requests have priority over instruction fetches.
- A timeout counter traps RAM errors or a hung RAM.

Parameters:
TIMEOUT, 64, maximum cycles a RAM access may stay outstanding before the ERR trap (range 2..255)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  reset, synchronous, active-high
iREN  in  1  instruction fetch request, held by requester until ihit
iaddr  in  32  fetch word address
dREN  in  1  data load request, held until dhit
dWEN  in  1  data store request, held until dhit
daddr  in  32  data word address
dstore  in  32  store data
ihit  out  1  fetch complete, one-cycle pulse
iload  out  32  fetched instruction, valid while ihit=1 and held after
dhit  out  1  data access complete, one-cycle pulse
dload  out  32  load data, valid while dhit=1 and held after
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid when ramstate=ACCESS
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
memerr  out  1  sticky error flag

Behaviour:
- Reset (RST high at a posedge, from any state, including mid-access): state=IDLE; ihit, dhit, ramREN, ramWEN and memerr all 0; iload, dload, ramaddr and ramstore all 0x00000000; timeout counter 0. An in-flight access is abandoned, with no hit issued.
- All outputs are registered.
- States: IDLE, DREQ, IREQ, DONE, ERR.
- IDLE:
  - If dREN or dWEN: go to DREQ. Latch ramaddr=daddr and ramstore=dstore. Set ramWEN=dWEN and ramREN=dREN&!dWEN; when dREN and dWEN are both high, the store wins.
  - Else if iREN: go to IREQ with ramaddr=iaddr, ramREN=1, ramWEN=0.
  - Else stay in IDLE.
- DREQ/IREQ:
  - RAM enables, address and store data are held constant. The counter increments each cycle.
  - ramstate=ACCESS: go to DONE and drop ramREN/ramWEN. Pulse dhit (DREQ) or ihit (IREQ) in that DONE cycle. Capture ramload into dload on a DREQ read, or into iload on IREQ; dload is unchanged on a store.
  - ramstate=ERROR, or counter reaches TIMEOUT-1 without ACCESS: go to ERR.
  - Requester drops its request before ACCESS: abort to IDLE, enables 0, no hit.
  - ACCESS takes priority over a same-cycle request drop.
- DONE:
  - Lasts exactly 1 cycle, with ihit or dhit = 1.
  - Requests are ignored here, because the requester still presents a stale request during the hit cycle.
  - Next state is IDLE. The counter clears.
- ERR: memerr=1, all enables 0, no hits. Stays until RST.
- Latency: request sampled in IDLE at edge 0 → RAM enables visible cycle 1 → ramstate=ACCESS sampled at edge k (k≥1) → hit visible in cycle k+1.
  - Minimum request-to-hit latency is 2 cycles.
  - Back-to-back accesses from the same requester are spaced by DONE+IDLE: at most one access per 3 cycles for 1-cycle RAM.
- Arbitration:
  - dREN/dWEN and iREN pending together in IDLE: data is served first, then the fetch on the next IDLE visit.
  - Data priority is absolute. A fetch waits while data requests are continuously re-asserted.
- Counter: 8-bit, saturating, cleared on entry to DREQ/IREQ.
- ihit and dhit are never high in the same cycle, and neither is ever high for two consecutive cycles.

Test Plan:
- RST=1 for 2 cycles, then iREN=1 with iaddr=0x0000_0040; RAM returns ACCESS in 1 cycle with ramload=0x2002_0001 → ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1 and iload=0x2002_0001 in cycle 2; ihit=0 in cycle 3.
- Simultaneous dREN (daddr=0x100, RAM data 0xDEAD_BEEF) and iREN (iaddr=0x44) → dhit pulses first with dload=0xDEAD_BEEF; ramaddr=0x44 appears only after DONE and IDLE; ihit follows.
- dWEN=1 with daddr=0x200 and dstore=0x1234_5678; RAM BUSY 3 cycles, then ACCESS → ramWEN=1, ramREN=0, ramstore=0x1234_5678 held for 4 cycles; dhit in cycle 5; dload unchanged.
- Requester holds dREN=1 through the dhit cycle → exactly one RAM access; no second ramREN until the request is re-presented in IDLE.
- TIMEOUT=8 with ramstate stuck at BUSY → memerr=1 after 8 cycles in DREQ; enables 0; no hits; RST=1 clears memerr=0 and returns to IDLE.
- RST asserted mid-IREQ (RAM BUSY) → next cycle ramREN=0, ihit=0, state IDLE; a fresh fetch afterwards completes normally.
